// File: rtl/cdc_hsk_pkg.sv
// Shared types for the destination side of the full-handshake bus CDC.
// The FSM only needs to know whether a transfer is currently being acknowledged.
package cdc_hsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hsk_dst_state_e;

endpackage : cdc_hsk_pkg

// File: rtl/cdc_hsk_fifo.sv
// Small synchronous FIFO with a register-array store and a registered occupancy count.
// The head word is read combinationally from the array, so it holds steady until a pop.
module cdc_hsk_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic              do_push;
  logic              do_pop;

  // Overflow and underflow are ignored here even if the caller misbehaves.
  assign full_o  = (fill_q == FILL_W'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign data_o = mem_q[rd_ptr_q];
  assign fill_o = fill_q;

  // Storage is data-only and left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   fill_q <= fill_q + FILL_W'(1);
        2'b01:   fill_q <= fill_q - FILL_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule : cdc_hsk_fifo

// File: rtl/cdc_hsk_dst_ctrl.sv
// Destination-side controller for the full-handshake CDC: four-phase ack generation,
// one FIFO push per handshake, valid/ready output stream and a completed-transfer count.
module cdc_hsk_dst_ctrl
  import cdc_hsk_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            hsk_req_i,
  input  logic [DATA_WIDTH-1:0]           hsk_data_i,
  output logic                            hsk_ack_o,
  output logic                            m_valid_o,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  input  logic                            m_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_o,
  output logic [CNT_WIDTH-1:0]            xfer_cnt_o
);

  hsk_dst_state_e       state_q;
  logic                 ack_q;
  logic [CNT_WIDTH-1:0] xfer_cnt_q;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  // Push only from IDLE: req stays high through ACK for the same word, and a
  // full FIFO simply withholds ack so the source stalls. Gating on req also
  // keeps junk on hsk_data_i (req low) out of the buffer.
  assign push = (state_q == IDLE) & hsk_req_i & ~full;
  assign pop  = m_valid_o & m_ready_i;

  cdc_hsk_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (hsk_data_i),
    .pop_i   (pop),
    .data_o  (m_data_o),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (!hsk_req_i) begin
            ack_q      <= 1'b0;
            xfer_cnt_q <= xfer_cnt_q + CNT_WIDTH'(1);
            state_q    <= IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hsk_ack_o  = ack_q;
  assign m_valid_o  = ~empty;
  assign xfer_cnt_o = xfer_cnt_q;

endmodule : cdc_hsk_dst_ctrl
